de_emphasis: RTL
================

// Module: de_emphasis
// PURPOSE
//  First-order IIR de-emphasis filter, the inverse of the team's pre-emphasis stage: y[n] = x[n] + ALPHA*y[n-1].
//  Restores the spectral tilt of pre-emphasized audio (synthesis/resynthesis path, round-trip verification of MFCC front end).
//  Sequential multiply-add with ready/valid on both sides, per-frame state clear, saturation with sticky flag.
// PARAMETERS
//  DATA_W  16     sample width, signed Q1.15 (all arithmetic below written for 16)
//  ALPHA   31785  feedback coefficient, signed Q1.15 (0.97); must be >= 0
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       async active-low reset
//  in_valid     in   1       x_in/frame_start valid
//  in_ready     out  1       block can accept a sample
//  frame_start  in   1       qualifies accepted sample: first of frame, y[n-1] treated as 0
//  x_in         in   DATA_W  signed input sample x[n]
//  out_valid    out  1       y_out valid
//  out_ready    in   1       downstream accepts y_out
//  y_out        out  DATA_W  signed output sample y[n]
//  sat_flag     out  1       sticky: some output in current frame saturated
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, y_out=0, sat_flag=0, y_prev=0, prod=0, x_reg=0.
//  FSM: IDLE -> MUL -> ADD -> OUT -> IDLE.
//   IDLE: in_ready=1. On in_valid: x_reg<=x_in; if frame_start, y_prev<=0 and sat_flag<=0; go MUL.
//   MUL : prod <= y_prev * ALPHA (signed 32-bit, full precision); go ADD.
//   ADD : sum = x_reg + (prod >>> 15) in 17 bits (arith shift = floor);
//         sat = clamp(sum, -32768, 32767); y_out<=sat; y_prev<=sat; out_valid<=1;
//         if sum out of range, sat_flag<=1; go OUT.
//   OUT : out_valid=1, y_out held stable; on out_ready: out_valid<=0, go IDLE. Otherwise stay.
//  in_ready is 1 only in IDLE (registered from state, no combinational path from out_ready).
//  Latency: handshake at cycle T -> out_valid=1 in cycle T+3. Max throughput 1 sample / 4 cycles.
//  frame_start ignored unless in_valid && in_ready. frame_start on the very first sample after reset is harmless (y_prev already 0).
//  Feedback uses the saturated value (no wrap). y_prev persists across samples until frame_start or reset.
//  sat_flag cleared only by reset or accepted frame_start; it sets in the same cycle y_out is updated.
//  Backpressure: out_ready low holds state in OUT indefinitely; no input accepted; no data lost or duplicated.
//  Reset mid-operation (any state): all registers return to reset values immediately; any sample in flight is discarded.
//  x_in sampled only at handshake; changes on x_in at other times have no effect.
// TESTING
//  1 Reset: assert rst_n=0 mid-MUL -> out_valid=0, y_out=0, in_ready=1, sat_flag=0 without a clock edge.
//  2 Impulse: frame_start + x=1000, then x=0,0 (out_ready=1) -> y=1000, 970, 940; first out_valid exactly 3 cycles after handshake.
//  3 Pos saturation: frame_start + 30000, then 30000 -> y=30000, 32767 (sum 59099), sat_flag=1; next frame_start clears sat_flag.
//  4 Neg saturation: frame_start + -32768, then -32768 -> y=-32768, -32768 (sum -64553), sat_flag=1.
//  5 Backpressure: out_ready=0 for 5 cycles after out_valid -> y_out stable, in_ready=0, held in_valid sample not taken; release -> accepted next IDLE cycle.
//  6 Round trip: 256 random samples (|x|<=8000) -> pre-emphasis -> de_emphasis -> output matches original within +/-34 LSB; frame_start resets state.

Source files
------------

// File: rtl/de_emphasis_if.sv
// Sample stream bundle for the de-emphasis filter.
// Input side and output side each use a valid/ready pair.
interface de_emphasis_if #(
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     frame_start;
  logic signed [DATA_W-1:0] x_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] y_out;
  logic                     sat_flag;

  modport slave (
    input  in_valid, frame_start, x_in, out_ready,
    output in_ready, out_valid, y_out, sat_flag
  );

  modport master (
    output in_valid, frame_start, x_in, out_ready,
    input  in_ready, out_valid, y_out, sat_flag
  );
endinterface

// File: rtl/de_emphasis.sv
// First-order IIR de-emphasis: y[n] = x[n] + ALPHA*y[n-1].
// One shared multiply-add per sample, saturating, sticky per-frame flag.
module de_emphasis #(
  parameter int DATA_W = 16,
  parameter int ALPHA  = 31785
) (
  input  logic          clk,
  input  logic          rst_n,
  de_emphasis_if.slave  bus
);
  localparam int PW = 2 * DATA_W;
  localparam int SW = DATA_W + 1;

  localparam logic signed [DATA_W-1:0] COEF = DATA_W'(ALPHA);
  localparam logic signed [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ADD,
    OUT
  } state_t;

  state_t state;
  state_t state_nx;

  logic signed [DATA_W-1:0] x_reg;
  logic signed [DATA_W-1:0] y_prev;
  logic signed [DATA_W-1:0] y_reg;
  logic signed [PW-1:0]     prod;
  logic                     sat_reg;

  logic signed [PW-1:0]     scaled;
  logic signed [SW-1:0]     sum;
  logic                     ovf;
  logic signed [DATA_W-1:0] sat_v;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.in_valid) state_nx = MUL;
      MUL:  state_nx = ADD;
      ADD:  state_nx = OUT;
      OUT:  if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Arithmetic shift floors the Q2.30 product back to Q1.15.
  always_comb begin
    scaled = prod >>> (DATA_W - 1);
    sum    = SW'(x_reg) + SW'(scaled);
    ovf    = sum[SW-1] != sum[SW-2];
    sat_v  = sum[DATA_W-1:0];
    if (ovf) sat_v = sum[SW-1] ? MINV : MAXV;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg   <= '0;
      y_prev  <= '0;
      y_reg   <= '0;
      prod    <= '0;
      sat_reg <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_reg <= bus.x_in;
            if (bus.frame_start) begin
              y_prev  <= '0;
              sat_reg <= 1'b0;
            end
          end
        end
        MUL: prod <= PW'(y_prev) * PW'(COEF);
        ADD: begin
          y_reg  <= sat_v;
          y_prev <= sat_v;
          if (ovf) sat_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == OUT;
  assign bus.y_out     = y_reg;
  assign bus.sat_flag  = sat_reg;
endmodule
